// File: rtl/wm_pkg.sv
// Shared types and time constants for the laundromat water-valve arbiter.
package wm_pkg;

  typedef enum logic [1:0] {
    StIdle,
    StGrant,
    StSettle
  } state_t;

  localparam int unsigned TICKS_PER_SEC = 250;
  localparam int unsigned FILL_MAX_SEC  = 120;
  localparam int unsigned SETTLE_SEC    = 1;

  function automatic int unsigned max_u(input int unsigned a, input int unsigned b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/wm_rr_pick.sv
// Combinational round-robin picker: first eligible index strictly after last_i, with wrap.
module wm_rr_pick
  import wm_pkg::*;
#(
  parameter int unsigned N_REQ = 4,
  localparam int unsigned IW   = $clog2(N_REQ)
) (
  input  logic [N_REQ-1:0] eligible_i,
  input  logic [IW-1:0]    last_i,
  output logic [N_REQ-1:0] pick_o,
  output logic             valid_o
);

  logic [IW-1:0] idx;

  always_comb begin
    pick_o  = '0;
    valid_o = 1'b0;
    idx     = '0;
    // Offsets 1..N_REQ so last_i itself is considered only after everyone else.
    for (int unsigned i = 1; i <= N_REQ; i++) begin
      idx = IW'((32'(last_i) + i) % N_REQ);
      if (!valid_o && eligible_i[idx]) begin
        pick_o[idx] = 1'b1;
        valid_o     = 1'b1;
      end
    end
  end

endmodule

// File: rtl/wm_water_arbiter.sv
// Round-robin arbiter sharing one water valve among N_REQ machines, with fill
// timeout and a settling gap between consecutive grants.
module wm_water_arbiter
  import wm_pkg::*;
#(
  parameter int unsigned N_REQ    = 4,
  parameter int unsigned MAX_FILL = FILL_MAX_SEC * TICKS_PER_SEC,
  parameter int unsigned SETTLE   = SETTLE_SEC * TICKS_PER_SEC
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic [N_REQ-1:0] i_req,
  output logic [N_REQ-1:0] o_grant,
  output logic             o_valve,
  output logic [N_REQ-1:0] o_timeout,
  output logic             o_busy
);

  localparam int unsigned IW = $clog2(N_REQ);
  localparam int unsigned CW = $clog2(max_u(MAX_FILL, SETTLE) + 1);

  state_t           state_q;
  logic [CW-1:0]    cnt_q;
  logic [IW-1:0]    last_q;
  logic [N_REQ-1:0] grant_q;
  logic             valve_q;
  logic [N_REQ-1:0] timeout_q;

  logic [N_REQ-1:0] eligible;
  logic [N_REQ-1:0] pick;
  logic             pick_valid;
  logic [IW-1:0]    pick_idx;

  assign eligible = i_req & ~timeout_q;

  wm_rr_pick #(
    .N_REQ(N_REQ)
  ) u_pick (
    .eligible_i(eligible),
    .last_i    (last_q),
    .pick_o    (pick),
    .valid_o   (pick_valid)
  );

  always_comb begin
    pick_idx = '0;
    for (int unsigned i = 0; i < N_REQ; i++) begin
      if (pick[i]) pick_idx = IW'(i);
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q   <= StIdle;
      cnt_q     <= '0;
      last_q    <= IW'(N_REQ - 1);
      grant_q   <= '0;
      valve_q   <= 1'b0;
      timeout_q <= '0;
    end else begin
      // A flag drops as soon as its machine withdraws the request.
      timeout_q <= timeout_q & i_req;
      unique case (state_q)
        StIdle: begin
          if (pick_valid) begin
            grant_q <= pick;
            valve_q <= 1'b1;
            last_q  <= pick_idx;
            cnt_q   <= '0;
            state_q <= StGrant;
          end
        end
        StGrant: begin
          cnt_q <= cnt_q + CW'(1);
          if ((grant_q & i_req) == '0) begin
            grant_q <= '0;
            valve_q <= 1'b0;
            cnt_q   <= '0;
            state_q <= StSettle;
          end else if (cnt_q == CW'(MAX_FILL - 1)) begin
            grant_q   <= '0;
            valve_q   <= 1'b0;
            timeout_q <= (timeout_q & i_req) | grant_q;
            cnt_q     <= '0;
            state_q   <= StSettle;
          end
        end
        StSettle: begin
          if (cnt_q == CW'(SETTLE - 1)) begin
            cnt_q   <= '0;
            state_q <= StIdle;
          end else begin
            cnt_q <= cnt_q + CW'(1);
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign o_grant   = grant_q;
  assign o_valve   = valve_q;
  assign o_timeout = timeout_q;
  assign o_busy    = (state_q != StIdle);

endmodule
